// File: rtl/braille_pkg.sv
// braille_pkg: shared types, Grade-1 dot table and ASCII letter classification.
package braille_pkg;
  localparam int DOT_W = 6;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;
  localparam logic [DOT_W-1:0] DOT_LUT [26] = '{
    6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001,
    6'b001011, 6'b011011, 6'b010011, 6'b001010, 6'b011010,
    6'b000101, 6'b000111, 6'b001101, 6'b011101, 6'b010101,
    6'b001111, 6'b011111, 6'b010111, 6'b001110, 6'b011110,
    6'b100101, 6'b100111, 6'b111010, 6'b101101, 6'b111101,
    6'b110101
  };
  // Clearing bit5 folds lowercase onto uppercase; nothing outside the two letter ranges lands in 0x41-0x5A.
  function automatic logic [5:0] ascii_to_index(input logic [7:0] c);
    logic [7:0] u;
    u = c & 8'hDF;
    return (u >= 8'h41 && u <= 8'h5A) ? {1'b1, 5'(u - 8'h41)} : 6'd0;
  endfunction
endpackage

// File: rtl/braille_char_fifo.sv
// braille_char_fifo: synchronous FIFO of letter indices, no bypass when full.
module braille_char_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic push_ok, pop_ok;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok = pop_i && !empty_o;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_ok ? wr_q + 1'b1 : wr_q;
      rd_q <= pop_ok ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= data_i;
  end
endmodule

// File: rtl/braille_cell_driver.sv
// braille_cell_driver: buffers classifier letters and shows each as a Braille
// pattern for HOLD_CYC cycles followed by GAP_CYC cycles of all dots low.
module braille_cell_driver
  import braille_pkg::*;
#(
  parameter int HOLD_CYC = 50000000,
  parameter int GAP_CYC = 10000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [7:0]       i_alpha,
  output logic [DOT_W-1:0] o_dots,
  output logic             o_busy,
  output logic             o_empty,
  output logic             o_overflow,
  output logic             o_bad_char
);
  localparam int MAXC = HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DOT_W-1:0] dots_q, dots_d;
  logic busy_q, ovf_q, bad_q;
  logic [5:0] cls;
  logic letter, pop, full, empty;
  logic [4:0] head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  assign cls = ascii_to_index(i_alpha);
  assign letter = i_valid && cls[5];
  braille_char_fifo #(.DEPTH(FIFO_DEPTH), .W(5)) u_fifo (
    .clk(clk), .rst_n(reset_n), .push_i(letter), .data_i(cls[4:0]),
    .pop_i(pop), .data_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dots_d = dots_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        dots_d = DOT_LUT[head];
        cnt_d = HOLD_LD;
        state_d = HOLD;
      end
      HOLD: if (cnt_q == '0) begin
        dots_d = '0;
        cnt_d = GAP_LD;
        state_d = GAP;
      end else cnt_d = cnt_q - 1'b1;
      GAP: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else if (!empty) begin
        pop = 1'b1;
        dots_d = DOT_LUT[head];
        cnt_d = HOLD_LD;
        state_d = HOLD;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dots_q <= '0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dots_q <= dots_d;
      busy_q <= state_d != IDLE;
      ovf_q <= letter && full;
      bad_q <= i_valid && !cls[5];
    end
  end
  assign o_dots = dots_q;
  assign o_busy = busy_q;
  assign o_empty = count == '0;
  assign o_overflow = ovf_q;
  assign o_bad_char = bad_q;
endmodule

// File: doc/braille_cell_driver.md
Name: braille_cell_driver

Overview:
- Downstream consumer of the CNN classifier's `out_valid`/`alpha` result.
- Buffers recognised ASCII letters, converts each to a 6-dot Grade-1 Braille pattern, and drives the actuator outputs.
- Each character is held for a programmable time, then followed by a programmable all-dots-low gap.
- Absorbs bursts of classifier results so the CNN never waits on the slow mechanical cell.

Parameters:
- HOLD_CYC, 50000000: cycles a character's dot pattern is held (0.5 s @ 100 MHz); legal minimum 1.
- GAP_CYC, 10000000: cycles of all-dots-low between characters; legal minimum 1.
- FIFO_DEPTH, 4: character buffer depth; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  one-cycle strobe; `i_alpha` is valid this cycle (driven by classifier `out_valid`)
- i_alpha  in  8  ASCII character from classifier
- o_dots  out  6  actuator drive; bit0=dot1 … bit5=dot6; 1 = raised
- o_busy  out  1  high while a character is being held or a gap is running
- o_empty  out  1  high when the FIFO holds no characters
- o_overflow  out  1  one-cycle pulse: valid letter dropped because FIFO was full
- o_bad_char  out  1  one-cycle pulse: non-letter dropped

Behaviour:
- Reset is asynchronous active-low on `reset_n`. Reset values:
  - o_dots=0, o_busy=0, o_empty=1, o_overflow=0, o_bad_char=0
  - FIFO pointers and count cleared; state=IDLE; counter=0.
- Reset asserted mid-HOLD or mid-GAP aborts immediately: dots drop to 0 and buffered characters are discarded.
- Enqueue, on a cycle where `i_valid`=1:
  - Letter 'A'–'Z' (0x41–0x5A) or 'a'–'z' (0x61–0x7A): case-folded to a 5-bit index 0–25.
    - Written to the FIFO if not full.
    - If full: dropped and `o_overflow` pulses the next cycle.
  - Any other code: dropped; `o_bad_char` pulses the next cycle.
  - A full FIFO with a pop in the same cycle still counts as full; the push is dropped (no bypass).
- Dot mapping, standard Grade-1:
  - a=000001, b=000011, c=001001, d=011001, e=010001
  - f=001011, g=011011, h=010011, i=001010, j=011010
  - k–t = a–j with bit2 (dot3) set
  - u,v,x,y,z = a,b,c,d,e with bits 2 and 5 set
  - w=111010
- FSM states: IDLE, HOLD, GAP.
  - IDLE: if FIFO non-empty, pop the head, register its pattern into `o_dots`, load counter=HOLD_CYC-1, go to HOLD. `o_dots` changes on the clock edge after the pop decision.
    - An empty FIFO receiving a letter at edge N gives `o_dots` valid at edge N+2.
  - HOLD: `o_dots` is constant. When counter=0, set o_dots=0, load counter=GAP_CYC-1, go to GAP; otherwise decrement.
    - Pattern is high for exactly HOLD_CYC cycles.
  - GAP: o_dots=0. When counter=0:
    - FIFO non-empty: pop and go directly to HOLD with the new pattern (no IDLE cycle).
    - FIFO empty: go to IDLE.
    - Gap is exactly GAP_CYC cycles.
- `o_busy` = state≠IDLE, registered.
- `o_empty` reflects FIFO count registered at the same edge as the update.
- Counter width is $clog2 of max(HOLD_CYC, GAP_CYC)+1; it never wraps.
- Simultaneous enqueue and dequeue on a non-full FIFO: both occur and the count is unchanged.

Decomposition:
- braille_pkg contains:
  - state enum {IDLE, HOLD, GAP}
  - 26-entry dot-pattern constant array, indexed by letter index
  - function ascii_to_index returning {valid, idx[4:0]}
  - DOT_W=6 constant
- Sub-module braille_char_fifo: synchronous FIFO.
  - Parameterised by DEPTH and width 5.
  - Signals: push/pop/full/empty/count; asynchronous active-low reset.
- Top level: classification and overflow logic, FSM, hold/gap counter.

Test Plan (HOLD_CYC=8, GAP_CYC=4, FIFO_DEPTH=4):
- **Reset:** hold reset_n=0 → o_dots=0, o_busy=0, o_empty=1, no pulses.
- **Single character:** 'A' (0x41) at edge N → o_dots=000001 from N+2 for exactly 8 cycles, then 0 for 4 cycles, then IDLE with o_busy=0.
- **Back-to-back burst:** 'w','z','k' on consecutive cycles → 111010 (8), 0 (4), 110101 (8), 0 (4), 000101 (8), 0 (4); no idle cycle between gap and next hold.
- **Overflow:** 6 letters in consecutive cycles while HOLD is in progress → 4 buffered; o_overflow pulses once per dropped letter; only the first 5 letters are displayed (1 already popped + 4 buffered).
- **Bad character:** '3' (0x33) and 0x5B → o_bad_char pulses each time, FIFO unchanged, o_dots stays 0.
- **Reset mid-operation:** reset_n=0 mid-HOLD with 2 characters buffered → o_dots=0 immediately (asynchronous), o_empty=1; after release, nothing is displayed.
